result_packer: RTL and testbench
================================

Name: result_packer

Overview:
- Downstream stage of the registered datapath stage that produces a WIDTH-bit result and a 1-bit flag every cycle.
- Collects consecutive valid results in pairs and packs each pair into one MUL_WIDTH word with 2 flag bits.
- Buffers packed words in a small first-word-fall-through FIFO, drained by a valid/ready consumer.
- The upstream stage has no backpressure, so a pair that completes while the FIFO is full is dropped and flagged.

Parameters:
- WIDTH, 8, width of each incoming result
- DEPTH, 4, FIFO entries; power of 2, at least 2
- MUL_WIDTH, WIDTH*2, packed word width; fixed at 2*WIDTH, not overridden

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  data_in/flag_in valid this cycle
- data_in  input  WIDTH  upstream result
- flag_in  input  1  upstream flag
- flush  input  1  synchronous clear of partial pair and FIFO
- out_data  output  MUL_WIDTH  packed word {second, first}
- out_flags  output  2  {flag of second, flag of first}
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts head when out_valid is high
- count  output  $clog2(DEPTH)+1  FIFO occupancy
- overflow  output  1  sticky; a completed pair was dropped

Behaviour:
- Interface fact: one clock, clk; reset rst is asynchronous and active-high.
- Reset, applied at any time including mid-pair or mid-drain:
  - FSM goes to ST_LOW; partial register cleared.
  - FIFO empty; count=0; out_valid=0; out_data=0; out_flags=0; overflow=0.
- FSM ST_LOW:
  - in_valid=1: latch data_in into low_q and flag_in into lflag_q, then go to ST_HIGH.
- FSM ST_HIGH:
  - in_valid=1: form {data_in, low_q} and {flag_in, lflag_q}, attempt a push, then return to ST_LOW.
  - in_valid=0: hold state; there is no timeout.
- Push and pop rules:
  - Pop happens when out_valid && out_ready.
  - Push succeeds if count<DEPTH, or if a pop occurs in the same cycle (full with simultaneous pop is legal; count unchanged).
  - Push with FIFO full and no pop: the word is discarded, overflow is set to 1 (sticky until rst), and the FSM still returns to ST_LOW.
- Latency:
  - A pair completing in cycle N with the FIFO empty gives out_valid=1 with that word on out_data in cycle N+1.
  - No same-cycle bypass.
- Output is first-word-fall-through: out_data/out_flags show the head entry whenever out_valid=1, and are 0 when out_valid=0.
- Ordering: strict FIFO order; wrap-around of read and write pointers modulo DEPTH is transparent.
- Simultaneous push and pop when count=1: the old head leaves, the new word becomes head next cycle, count stays 1.
- flush=1:
  - FSM goes to ST_LOW, FIFO is emptied, count=0.
  - Any in_valid and out_ready in that cycle are ignored.
  - overflow is not cleared.
- out_ready while out_valid=0: no effect.

Optional Feature:
- Macro RESULT_PACKER_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = XOR of all bits of out_data, so even parity over word and parity bit.
  - out_parity is 0 when out_valid=0.
  - Computed at push time and stored as an extra FIFO column.
- Undefined: port and storage column are absent; all other behaviour is identical.

Decomposition:
- Package result_packer_pkg holds:
  - typedef enum logic {ST_LOW, ST_HIGH} rp_state_t
  - localparam function for pointer width, $clog2(DEPTH)
- Sub-module rp_fifo:
  - Parameterised synchronous FWFT FIFO (data width, DEPTH).
  - Ports: push, pop, wdata, rdata, full, empty, count, flush.
- result_packer contains the FSM, pair registers, overflow logic and the optional parity.

Test Plan:
- Reset mid-pair: in_valid with 0x11, then assert rst asynchronously between edges -> all outputs 0 immediately; next pair 0x22, 0x33 -> out_data=0x3322.
- Basic pack, out_ready=1: inputs 0xA5 (flag 1), 0x3C (flag 0) back-to-back -> out_valid the cycle after the second, out_data=0x3CA5, out_flags=2'b01, count returns to 0.
- Gapped input: 0x01, three idle cycles, 0x02 -> single word 0x0201; no output during the gap.
- Fill and overflow, out_ready=0: 10 results 0x00..0x09 -> count=4; words 0x0100, 0x0302, 0x0504, 0x0706; overflow=1 after the fifth pair; drain gives exactly those 4 in order.
- Full with simultaneous pop: FIFO full, out_ready=1 in the cycle a pair 0xBBAA completes -> no overflow, count stays 4, 0xBBAA is drained last.
- Flush plus parity build: 0x55 then flush, then 0x0F, 0xF0 -> only word 0xF00F; with RESULT_PACKER_PARITY_EN, out_parity=0; for pair 0x01, 0x00 -> out_parity=1.

Source files
------------

// File: rtl/result_packer_pkg.sv
// Shared types and helpers for the result packer.
package result_packer_pkg;

    typedef enum logic {ST_LOW, ST_HIGH} rp_state_t;

    // Pointer width for a power-of-2 FIFO depth
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/rp_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata reads 0 while empty.
module rp_fifo
    import result_packer_pkg::*;
#(
    parameter int unsigned DW    = 18,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [DW-1:0]          wdata,
    output logic [DW-1:0]          rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == CW'(0));
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    // Storage array; contents are only observed behind a valid head
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy tracks push/pop balance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Head entry presented directly, forced to 0 when nothing is stored
    always_comb begin
        rdata = '0;
        if (!empty) begin
            rdata = mem[rptr];
        end
    end

endmodule

// File: rtl/result_packer.sv
// Packs consecutive valid results in pairs into a FWFT FIFO.
// Optional feature: define RESULT_PACKER_PARITY_EN to add out_parity.
module result_packer
    import result_packer_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MUL_WIDTH = WIDTH * 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   flag_in,
    input  logic                   flush,
    output logic [MUL_WIDTH-1:0]   out_data,
    output logic [1:0]             out_flags,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
`ifdef RESULT_PACKER_PARITY_EN
    ,
    output logic                   out_parity
`endif
);

`ifdef RESULT_PACKER_PARITY_EN
    localparam int unsigned FW = MUL_WIDTH + 3;
`else
    localparam int unsigned FW = MUL_WIDTH + 2;
`endif

    rp_state_t          state;
    logic [WIDTH-1:0]   low_q;
    logic               lflag_q;

    logic               pair_done_c;
    logic               pop_c;
    logic               push_c;
    logic               full;
    logic               empty;
    logic [MUL_WIDTH-1:0] word_c;
    logic [1:0]         flags_c;
    logic [FW-1:0]      wdata;
    logic [FW-1:0]      rdata;

    assign word_c      = {data_in, low_q};
    assign flags_c     = {flag_in, lflag_q};
    assign out_valid   = !empty;
    assign pair_done_c = !flush && in_valid && (state == ST_HIGH);
    assign pop_c       = !flush && out_valid && out_ready;
    assign push_c      = pair_done_c && (!full || pop_c);

`ifdef RESULT_PACKER_PARITY_EN
    assign wdata      = {^word_c, flags_c, word_c};
    assign out_parity = rdata[MUL_WIDTH+2];
`else
    assign wdata      = {flags_c, word_c};
`endif
    assign out_data  = rdata[MUL_WIDTH-1:0];
    assign out_flags = rdata[MUL_WIDTH+1:MUL_WIDTH];

    // Pair-collection FSM: hold the first result until its partner arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_LOW;
            low_q   <= '0;
            lflag_q <= 1'b0;
        end else if (flush) begin
            state   <= ST_LOW;
            low_q   <= '0;
            lflag_q <= 1'b0;
        end else if (in_valid) begin
            if (state == ST_LOW) begin
                low_q   <= data_in;
                lflag_q <= flag_in;
                state   <= ST_HIGH;
            end else begin
                state   <= ST_LOW;
            end
        end
    end

    // Sticky record of a completed pair that found no room
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (pair_done_c && full && !pop_c) begin
            overflow <= 1'b1;
        end
    end

    rp_fifo #(
        .DW    (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .pop   (pop_c),
        .flush (flush),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_result_packer.sv
// Self-checking bench for result_packer: vector table plus scoreboard.
module tb_result_packer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  data_in;
    logic        flag_in;
    logic        flush;
    logic [15:0] out_data;
    logic [1:0]  out_flags;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;
    logic        overflow;
`ifdef RESULT_PACKER_PARITY_EN
    logic        out_parity;
`endif

    result_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .flag_in   (flag_in),
        .flush     (flush),
        .out_data  (out_data),
        .out_flags (out_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
`ifdef RESULT_PACKER_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       f;
        logic       rdy;
        logic       fl;
        int         exp_cnt;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  f;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    int   tests = 0;
    int   fails = 0;

    logic       m_high;
    logic [7:0] m_low;
    logic       m_lf;
    int         m_cnt;
    logic       m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear(input logic clr_ovf);
        m_high = 1'b0;
        m_low  = '0;
        m_lf   = 1'b0;
        m_cnt  = 0;
        sb.delete();
        if (clr_ovf) m_ovf = 1'b0;
    endtask

    task automatic add(input logic iv, input logic [7:0] d, input logic f,
                       input logic rdy, input logic fl, input int ec);
        vec_t v;
        v.iv = iv; v.d = d; v.f = f; v.rdy = rdy; v.fl = fl; v.exp_cnt = ec;
        tbl.push_back(v);
    endtask

    // One cycle: check current outputs against the model, drive, advance
    task automatic step(input logic iv, input logic [7:0] d, input logic f,
                        input logic rdy, input logic fl, input int ec);
        logic pop_m;
        exp_t e;
        in_valid  = iv;
        data_in   = d;
        flag_in   = f;
        out_ready = rdy;
        flush     = fl;
        chk("out_valid", 32'(out_valid), 32'(m_cnt > 0));
        chk("count", 32'(count), 32'(m_cnt));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (sb.size() > 0) begin
            chk("out_data", 32'(out_data), 32'(sb[0].d));
            chk("out_flags", 32'(out_flags), 32'(sb[0].f));
`ifdef RESULT_PACKER_PARITY_EN
            chk("out_parity", 32'(out_parity), 32'(^sb[0].d));
`endif
        end else begin
            chk("idle_data", 32'(out_data), 32'(0));
            chk("idle_flags", 32'(out_flags), 32'(0));
`ifdef RESULT_PACKER_PARITY_EN
            chk("idle_parity", 32'(out_parity), 32'(0));
`endif
        end
        if (fl) begin
            model_clear(1'b0);
        end else begin
            pop_m = rdy && (m_cnt > 0);
            if (iv) begin
                if (m_high) begin
                    e.d = {d, m_low};
                    e.f = {f, m_lf};
                    if (m_cnt < DEPTH || pop_m) begin
                        sb.push_back(e);
                        m_cnt++;
                    end else begin
                        m_ovf = 1'b1;
                    end
                    m_high = 1'b0;
                end else begin
                    m_low  = d;
                    m_lf   = f;
                    m_high = 1'b1;
                end
            end
            if (pop_m) begin
                void'(sb.pop_front());
                m_cnt--;
            end
        end
        @(negedge clk);
        if (ec >= 0) chk("tbl_count", 32'(count), 32'(ec));
    endtask

    // Assert reset between edges and verify outputs clear immediately
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_data", 32'(out_data), 32'(0));
        chk("rst_flags", 32'(out_flags), 32'(0));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_ovf", 32'(overflow), 32'(0));
        model_clear(1'b1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; data_in = '0; flag_in = 1'b0;
        flush = 1'b0; out_ready = 1'b0;
        model_clear(1'b1);
        repeat (2) @(negedge clk);
        chk("init_valid", 32'(out_valid), 32'(0));
        chk("init_count", 32'(count), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // Reset mid-pair with a stored word, then a fresh pair
        step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0, -1);
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1);
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1);
        async_reset();
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1);
        chk("rst_pair_word", 32'(out_data), 32'(16'h3322));
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0);

        // Vector table: basic pack, gapped input, fill/overflow and drain
        add(1, 8'hA5, 1, 1, 0, 0);
        add(1, 8'h3C, 0, 1, 0, 1);
        add(0, 8'h00, 0, 1, 0, 0);
        add(1, 8'h01, 0, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0);
        add(1, 8'h02, 0, 1, 0, 1);
        add(0, 8'h00, 0, 1, 0, 0);
        add(1, 8'h00, 0, 0, 0, 0);
        add(1, 8'h01, 1, 0, 0, 1);
        add(1, 8'h02, 0, 0, 0, 1);
        add(1, 8'h03, 1, 0, 0, 2);
        add(1, 8'h04, 0, 0, 0, 2);
        add(1, 8'h05, 0, 0, 0, 3);
        add(1, 8'h06, 1, 0, 0, 3);
        add(1, 8'h07, 1, 0, 0, 4);
        add(1, 8'h08, 0, 0, 0, 4);
        add(1, 8'h09, 0, 0, 0, 4);
        add(0, 8'h00, 0, 1, 0, 3);
        add(0, 8'h00, 0, 1, 0, 2);
        add(0, 8'h00, 0, 1, 0, 1);
        add(0, 8'h00, 0, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].iv, tbl[i].d, tbl[i].f, tbl[i].rdy, tbl[i].fl, tbl[i].exp_cnt);
        end
        chk("ovf_after_fill", 32'(overflow), 32'(1));

        // Flush drops the partial pair and stored words but keeps overflow
        step(1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 8'h34, 1'b0, 1'b0, 1'b0, 1);
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1);
        step(1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 0);
        chk("ovf_kept_flush", 32'(overflow), 32'(1));
        step(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 1);
        chk("flush_word", 32'(out_data), 32'(16'hF00F));
`ifdef RESULT_PACKER_PARITY_EN
        chk("parity_even", 32'(out_parity), 32'(0));
`endif
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0);

        // Full FIFO with a pop in the cycle a pair completes
        async_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'(i % 3 == 0), 1'b0, 1'b0, -1);
        end
        chk("full_count", 32'(count), 32'(4));
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 4);
        step(1'b1, 8'hBB, 1'b1, 1'b1, 1'b0, 4);
        chk("full_pop_ovf", 32'(overflow), 32'(0));
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1);
        chk("last_word", 32'(out_data), 32'(16'hBBAA));
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0);

        // Odd-weight word for the parity column
        step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1);
        chk("odd_word", 32'(out_data), 32'(16'h0001));
`ifdef RESULT_PACKER_PARITY_EN
        chk("parity_odd", 32'(out_parity), 32'(1));
`endif
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
